// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// DmemArbiter (module dmem_arbiter)
//
// Shares one single-ported synchronous data memory between two requesters:
// port 0 is the CPU memory stage, port 1 a secondary master (loader, DMA,
// debug). At most one access reaches the memory per cycle. Read data is
// routed back to the port that issued the read. A port can hold ownership
// across several accesses by keeping its lock input high.
//
// Ports:
//   clock, reset           single clock, synchronous active-high reset
//   reqN, weN              access request and write (1) / read (0) select
//   addrN, wdataN          access address and write data
//   lockN                  keep ownership after the current access
//   gntN                   access accepted this cycle (combinational)
//   rvalidN, rdataN        read return, one cycle after the read grant
//   mem_addr, mem_wenable,
//   mem_wvalue             memory request side
//   mem_rvalue             memory read data, valid the cycle after the address
//
// Build option:
//   DMEM_ARB_ROUND_ROBIN_EN  defined: a tie in the FREE state goes to the
//                            port that was not granted most recently.
//                            undefined: port 0 always wins a FREE tie.
//------------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic                  lock0,
    input  logic                  lock1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wenable,
    output logic [DATA_WIDTH-1:0] mem_wvalue,
    input  logic [DATA_WIDTH-1:0] mem_rvalue
);

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } OwnerState;

    OwnerState             r_owner;
    OwnerState             w_ownerNext;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_rvalid0;
    logic                  w_rvalid1;
    logic                  r_rdPend;
    logic                  r_rdPort;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic                  r_last;
`endif

    // Grant selection and next owner. A lock holder is the only port that can
    // be granted; the lock is dropped in any cycle its lock input is low,
    // whether or not that port is requesting. Grants are suppressed while
    // reset is high so every output reads zero during reset.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_ownerNext = r_owner;
        if (!reset) begin
            case (r_owner)
                LOCK0: begin
                    w_gnt0      = req0;
                    w_ownerNext = lock0 ? LOCK0 : FREE;
                end
                LOCK1: begin
                    w_gnt1      = req1;
                    w_ownerNext = lock1 ? LOCK1 : FREE;
                end
                default: begin
                    if (req0 && req1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        if (r_last) begin
                            w_gnt0 = 1'b1;
                        end else begin
                            w_gnt1 = 1'b1;
                        end
`else
                        w_gnt0 = 1'b1;
`endif
                    end else begin
                        w_gnt0 = req0;
                        w_gnt1 = req1;
                    end
                    if (w_gnt0) begin
                        w_ownerNext = lock0 ? LOCK0 : FREE;
                    end else if (w_gnt1) begin
                        w_ownerNext = lock1 ? LOCK1 : FREE;
                    end else begin
                        w_ownerNext = FREE;
                    end
                end
            endcase
        end
    end

    // Owner state, in-flight read tracking and held read data. rdPend only
    // lives for the one cycle between a read grant and its data return.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner  <= FREE;
            r_rdPend <= 1'b0;
            r_rdPort <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_owner  <= w_ownerNext;
            r_rdPend <= (w_gnt0 && !we0) || (w_gnt1 && !we1);
            r_rdPort <= w_gnt1;
            if (w_rvalid0) begin
                r_rdata0 <= mem_rvalue;
            end
            if (w_rvalid1) begin
                r_rdata1 <= mem_rvalue;
            end
        end
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // Most recently granted port; starts at 1 so port 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (w_gnt0) begin
            r_last <= 1'b0;
        end else if (w_gnt1) begin
            r_last <= 1'b1;
        end
    end
`endif

    // Read return. The memory output register already provides the one-cycle
    // read latency, so the returning port sees mem_rvalue directly while the
    // other port keeps showing its last captured value.
    assign w_rvalid0 = r_rdPend && !r_rdPort && !reset;
    assign w_rvalid1 = r_rdPend &&  r_rdPort && !reset;

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = w_rvalid0;
    assign rvalid1 = w_rvalid1;
    assign rdata0  = w_rvalid0 ? mem_rvalue : r_rdata0;
    assign rdata1  = w_rvalid1 ? mem_rvalue : r_rdata1;

    // Memory request mux: only a granted port drives the memory, otherwise
    // everything is held at zero.
    assign mem_addr    = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
    assign mem_wvalue  = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);
    assign mem_wenable = (w_gnt0 && we0) || (w_gnt1 && we1);

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-ported synchronous data memory between the CPU memory stage (port 0) and a secondary master such as a loader, DMA or debug port (port 1). At most one access reaches memory per cycle, and read data is returned to the requester that issued it. Ownership can be locked for multi-access sequences. The block sits between the CPU's dmem port and the data memory instance.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: address width; matches `DMEM_ADDR_WIDTH`.
- `DATA_WIDTH`, default 8: data width; matches `DMEM_DATA_WIDTH`.

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1: access request.
- `we0`, `we1` input 1: 1 = write, 0 = read; valid while the matching req is high.
- `addr0`, `addr1` input ADDR_WIDTH: access address.
- `wdata0`, `wdata1` input DATA_WIDTH: write data.
- `lock0`, `lock1` input 1: keep ownership after the current access.
- `gnt0`, `gnt1` output 1: access accepted this cycle (combinational).
- `rvalid0`, `rvalid1` output 1: read data valid (registered).
- `rdata0`, `rdata1` output DATA_WIDTH: read data (registered).
- `mem_addr` output ADDR_WIDTH: memory address.
- `mem_wenable` output 1: memory write strobe.
- `mem_wvalue` output DATA_WIDTH: memory write data.
- `mem_rvalue` input DATA_WIDTH: memory read data, valid the cycle after the address.

## Operation
- State register `owner` takes one of:
  - FREE: no lock held.
  - LOCK0: port 0 holds the lock.
  - LOCK1: port 1 holds the lock.
- Also registered: `last` (port most recently granted), `rd_pend` (a read is in flight), `rd_port` (which port issued it).
- Grant selection each cycle:
  - LOCK0: only port 0 may be granted; `req1` is ignored.
  - LOCK1: only port 1 may be granted; `req0` is ignored.
  - FREE, one requester: that requester is granted.
  - FREE, both requesting: see Configuration.
- A granted port drives `mem_addr`, `mem_wenable` (= its `we`) and `mem_wvalue`.
- With no grant: `mem_addr`=0, `mem_wenable`=0, `mem_wvalue`=0. `mem_wenable` is never high without a grant.
- State transitions on a granted access from port k:
  - `lock_k`=1 → LOCKk.
  - `lock_k`=0 → FREE.
  - Any cycle in LOCKk where `lock_k` falls → FREE, whether or not port k requests.
- A granted read sets `rd_pend`=1 and `rd_port`=k. Otherwise `rd_pend`=0.
- Read return: `rvalid_k`=1 and `rdata_k`=`mem_rvalue` one cycle after the grant. The other port's `rvalid` stays 0 and its `rdata` holds its previous value.
- Writes produce no `rvalid`.

## Timing
- Reset values:
  - Outputs: all `gnt`, `rvalid`, `rdata`, `mem_*` = 0.
  - State: `owner`=FREE, `last`=1 (so port 0 wins the first tie), `rd_pend`=0.
- Grant latency is 0: gnt is combinational from req in the same cycle. Requesters hold req/we/addr/wdata stable until they see gnt.
- Read latency: rvalid arrives exactly 1 cycle after gnt. Back-to-back reads give 1 read per cycle.
- A read followed by a write from the other port in the next cycle is legal: the rvalid for the read and the grant for the write occur in the same cycle.
- Reset mid-operation: an in-flight read is dropped (no rvalid) and any lock is released.
- A lock asserted on a write behaves the same as on a read.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined:
  - FREE tie goes to the port not equal to `last`.
  - `last` updates on every grant.
- Not defined:
  - Fixed priority: port 0 always wins a FREE tie.
  - `last` is unused and may be optimized away.
- Locking and read-return behaviour are identical in both builds.

## Test plan
- Port 0 only reads addr 0x10, memory holds 0x5A → `gnt0`=1 in cycle N; `rvalid0`=1 and `rdata0`=0x5A in N+1; `rvalid1`=0.
- Both ports request reads every cycle, fixed priority build → port 0 granted every cycle.
- Same stimulus, `DMEM_ARB_ROUND_ROBIN_EN` build → grants alternate 0,1,0,1; rdata routed to the matching port.
- Port 1 writes 0x33 to 0x20 with `lock1`=1, then port 0 requests for 3 cycles while `lock1` stays high → `gnt0`=0 throughout. After `lock1` falls, `gnt0`=1 the next cycle; a readback of 0x20 returns 0x33.
- Port 0 read granted, `reset` asserted the next cycle → `rvalid0`=0, `owner`=FREE, all outputs 0.
- Simultaneous write from port 0 (`we0`=1) and read from port 1 in a FREE tie → exactly one `mem_wenable`/`mem_addr` set per cycle, never both ports driving memory.
